mem_byte_bridge: RTL and testbench

Bus adapter between the core's load/store port and the byte-wide test/peripheral memory. Takes one byte, halfword or word access, splits it into sequential single-byte request/valid transactions on the memory side, and reassembles little-endian read data with sign/zero extension. It returns a one-cycle completion pulse to the core. It sits directly upstream of the byte memory and drives its request, write, address and data inputs.

---
 rtl/mem_byte_bridge.sv | 160 ++++++++++++++++
 tb/tb_mem_byte_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_bridge.sv
// Core load/store to byte-wide memory bridge: one byte transaction per memory
// request, little-endian reassembly and sign/zero extension of load data.
module mem_byte_bridge #(
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_request,
    input  logic              i_write,
    input  logic [31:0]       i_address,
    input  logic [31:0]       i_data,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic [31:0]       o_data,
    output logic              o_data_DV,
    output logic              o_busy,
    output logic              o_mem_request,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [7:0]        o_mem_data,
    input  logic [7:0]        i_mem_data,
    input  logic              i_mem_data_DV
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_k, w_k_nxt;
    logic [31:0]       r_asm, w_asm_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_unsigned;

    logic [ADDR_W-1:0] w_base;
    logic [31:0]       w_wdata;
    logic              w_write;
    logic              w_mem_request;
    logic              w_data_dv;
    logic              w_busy;
    logic [ADDR_W-1:0] w_mem_address;
    logic [7:0]        w_mem_data;
    logic [31:0]       w_data;
    logic              w_unused_addr;

    assign w_unused_addr = ^i_address[31:ADDR_W];

    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] size,
                                           input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = signed'(a[7:0]);
        h = signed'(a[15:0]);
        case (size)
            2'b00:   extend = uns ? {24'd0, a[7:0]}  : {{24{b[7]}}, b};
            2'b01:   extend = uns ? {16'd0, a[15:0]} : {{16{h[15]}}, h};
            default: extend = a;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_k     <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && i_request) begin
            r_base     <= i_address[ADDR_W-1:0];
            r_wdata    <= i_data;
            r_write    <= i_write;
            r_size     <= i_size;
            r_unsigned <= i_unsigned;
        end
        r_asm <= w_asm_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_asm_nxt   = r_asm;
        case (r_state)
            S_IDLE: begin
                if (i_request) begin
                    w_state_nxt = S_REQ;
                    w_k_nxt     = 2'd0;
                    w_asm_nxt   = 32'd0;
                end
            end
            S_REQ:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_mem_data_DV) begin
                    if (!r_write) w_asm_nxt[{r_k, 3'b000} +: 8] = i_mem_data;
                    if (r_k == last_idx(r_size)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_k_nxt     = r_k + 2'd1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        w_base        = (r_state == S_IDLE) ? i_address[ADDR_W-1:0] : r_base;
        w_wdata       = (r_state == S_IDLE) ? i_data : r_wdata;
        w_write       = (r_state == S_IDLE) ? i_write : r_write;
        w_mem_request = (w_state_nxt == S_REQ);
        w_data_dv     = (w_state_nxt == S_DONE);
        w_busy        = (w_state_nxt != S_IDLE);
        w_mem_address = w_base + ADDR_W'(w_k_nxt);
        w_mem_data    = w_wdata[{w_k_nxt, 3'b000} +: 8];
        w_data        = (w_data_dv && !r_write) ? extend(w_asm_nxt, r_size, r_unsigned) : 32'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data        <= 32'd0;
            o_data_DV     <= 1'b0;
            o_busy        <= 1'b0;
            o_mem_request <= 1'b0;
            o_mem_write   <= 1'b0;
            o_mem_address <= '0;
            o_mem_data    <= 8'd0;
        end else begin
            o_data        <= w_data;
            o_data_DV     <= w_data_dv;
            o_busy        <= w_busy;
            o_mem_request <= w_mem_request;
            if (w_mem_request) begin
                o_mem_address <= w_mem_address;
                o_mem_write   <= w_write;
                o_mem_data    <= w_mem_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Directed bench for mem_byte_bridge: byte memory model with programmable
// acknowledge stall, request/completion scoreboards checked every cycle.
module tb_mem_byte_bridge;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_request, i_write, i_unsigned;
    logic [31:0]       i_address, i_data;
    logic [1:0]        i_size;
    logic [31:0]       o_data;
    logic              o_data_DV, o_busy, o_mem_request, o_mem_write;
    logic [ADDR_W-1:0] o_mem_address;
    logic [7:0]        o_mem_data;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    always #5 clk = ~clk;

    mem_byte_bridge #(.ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_reset(rst), .i_request(i_request), .i_write(i_write),
        .i_address(i_address), .i_data(i_data), .i_size(i_size), .i_unsigned(i_unsigned),
        .o_data(o_data), .o_data_DV(o_data_DV), .o_busy(o_busy),
        .o_mem_request(o_mem_request), .o_mem_write(o_mem_write),
        .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
        .i_mem_data(mem_rdata), .i_mem_data_DV(mem_ack)
    );

    logic [7:0]  mem [0:4095];
    logic [11:0] stall_addr;
    int          stall_cycles;
    logic        pend;
    int          rem;

    assign mem_rdata = mem[o_mem_address];

    always @(posedge clk) begin
        if (rst) begin
            mem_ack <= 1'b0;
            pend    <= 1'b0;
            rem     <= 0;
        end else begin
            mem_ack <= 1'b0;
            if (o_mem_request) begin
                if (o_mem_address == stall_addr && stall_cycles > 0) begin
                    pend <= 1'b1;
                    rem  <= stall_cycles;
                end else begin
                    mem_ack <= 1'b1;
                end
            end else if (pend) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    mem_ack <= 1'b1;
                    pend    <= 1'b0;
                end
            end
        end
    end

    typedef struct { logic [11:0] addr; logic wr; logic [7:0] data; } req_t;
    typedef struct { logic [31:0] data; int cyc; } cpl_t;

    req_t        req_q[$];
    cpl_t        cpl_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          done_seen;
    bit          have_last;
    logic [31:0] last_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        req_t r;
        cpl_t c;
        @(posedge clk);
        #1;
        cyc++;
        if (o_mem_request) begin
            chk("req_expected", 32'(req_q.size() != 0), 32'd1);
            if (req_q.size() != 0) begin
                r = req_q.pop_front();
                chk("req_addr", 32'(o_mem_address), 32'(r.addr));
                chk("req_write", 32'(o_mem_write), 32'(r.wr));
                if (r.wr) chk("req_wdata", 32'(o_mem_data), 32'(r.data));
            end
            last_hold = {11'd0, o_mem_write, o_mem_data, o_mem_address};
            have_last = 1'b1;
        end else if (o_busy && have_last) begin
            chk("mem_hold", {11'd0, o_mem_write, o_mem_data, o_mem_address}, last_hold);
        end
        if (o_data_DV) begin
            done_seen = 1'b1;
            chk("dv_expected", 32'(cpl_q.size() != 0), 32'd1);
            if (cpl_q.size() != 0) begin
                c = cpl_q.pop_front();
                chk("o_data", o_data, c.data);
                chk("dv_cycle", 32'(cyc), 32'(c.cyc));
            end
        end
    endtask

    task automatic push_reqs(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                             input int n);
        req_t r;
        for (int k = 0; k < n; k++) begin
            r.addr = addr[11:0] + 12'(k);
            r.wr   = wr;
            r.data = data[8*k +: 8];
            req_q.push_back(r);
        end
    endtask

    task automatic push_cpl(input logic [31:0] data, input int at);
        cpl_t c;
        c.data = data;
        c.cyc  = at;
        cpl_q.push_back(c);
    endtask

    task automatic start(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] size, input logic uns);
        i_request  = 1'b1;
        i_write    = wr;
        i_address  = addr;
        i_data     = data;
        i_size     = size;
        i_unsigned = uns;
        done_seen  = 1'b0;
        step();
        i_request  = 1'b0;
        i_write    = ~wr;
        i_address  = $urandom();
        i_data     = $urandom();
        i_size     = 2'($urandom_range(0, 3));
        i_unsigned = ~uns;
    endtask

    task automatic wait_done(input int bound);
        int i;
        i = 0;
        while (!done_seen && i < bound) begin
            step();
            i++;
        end
        chk("done_within_bound", 32'(done_seen), 32'd1);
    endtask

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input logic uns, input logic [31:0] exp,
                          input int extra);
        int n;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        push_reqs(addr, wr, data, n);
        push_cpl(exp, cyc + 2 * n + 1 + extra);
        start(wr, addr, data, size, uns);
        wait_done(60);
        step();
        chk("busy_after_done", 32'(o_busy), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_o_data"}, o_data, 32'd0);
        chk({tag, "_o_data_DV"}, 32'(o_data_DV), 32'd0);
        chk({tag, "_o_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_o_mem_request"}, 32'(o_mem_request), 32'd0);
        chk({tag, "_o_mem_write"}, 32'(o_mem_write), 32'd0);
        chk({tag, "_o_mem_address"}, 32'(o_mem_address), 32'd0);
        chk({tag, "_o_mem_data"}, 32'(o_mem_data), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_request = 1'b0; i_write = 1'b0; i_address = 32'd0; i_data = 32'd0;
        i_size = 2'b00; i_unsigned = 1'b0;
        stall_addr = 12'h000; stall_cycles = 0;
        have_last = 1'b0; last_hold = 32'd0; done_seen = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h020] = 8'h80; mem[12'h021] = 8'h7F; mem[12'h022] = 8'hC5;
        mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hB2; mem[12'h000] = 8'hC3; mem[12'h001] = 8'hD4;
        mem[12'h100] = 8'h01; mem[12'h101] = 8'h02; mem[12'h102] = 8'h03; mem[12'h103] = 8'h84;
        mem[12'h030] = 8'h5A; mem[12'h031] = 8'hA5; mem[12'h032] = 8'h3C; mem[12'h033] = 8'hC3;

        repeat (2) step();
        chk_outputs_zero("reset");
        rst = 1'b0;
        step();

        access(1'b1, 32'h0000_0010, 32'h1122_3344, 2'b10, 1'b0, 32'h0000_0000, 0);
        access(1'b0, 32'h0000_0020, 32'h0, 2'b01, 1'b0, 32'h0000_7F80, 0);
        access(1'b0, 32'h0000_0020, 32'h0, 2'b00, 1'b0, 32'hFFFF_FF80, 0);
        access(1'b0, 32'h0000_0020, 32'h0, 2'b00, 1'b1, 32'h0000_0080, 0);
        access(1'b0, 32'h0000_0021, 32'h0, 2'b01, 1'b0, 32'hFFFF_C57F, 0);
        access(1'b0, 32'h0000_0021, 32'h0, 2'b01, 1'b1, 32'h0000_C57F, 0);
        access(1'b0, 32'hABCD_0FFE, 32'h0, 2'b10, 1'b0, 32'hD4C3_B2A1, 0);
        access(1'b1, 32'h0000_0FFF, 32'h0000_9A00, 2'b01, 1'b0, 32'h0000_0000, 0);

        // Core strobes while busy, including in the completion cycle, must be ignored.
        push_reqs(32'h100, 1'b0, 32'h0, 4);
        push_cpl(32'h8403_0201, cyc + 9);
        start(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        step();
        i_request = 1'b1; i_address = 32'h555; i_write = 1'b1; i_size = 2'b00;
        step();
        step();
        i_request = 1'b0;
        wait_done(60);
        i_request = 1'b1;
        step();
        chk("busy_after_pulsed_done", 32'(o_busy), 32'd0);
        i_request = 1'b0;
        repeat (4) step();

        stall_addr = 12'h031;
        stall_cycles = 5;
        access(1'b0, 32'h0000_0030, 32'h0, 2'b11, 1'b0, 32'hC33C_A55A, 5);
        stall_cycles = 0;

        // Reset in cycle 4 of a word store: only bytes 0 and 1 may ever be requested.
        push_reqs(32'h040, 1'b1, 32'hCAFE_F00D, 2);
        start(1'b1, 32'h040, 32'hCAFE_F00D, 2'b10, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk_outputs_zero("midreset");
        rst = 1'b0;
        have_last = 1'b0;
        repeat (12) step();

        access(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0000_0000, 0);
        access(1'b0, 32'h0000_0FFE, 32'h0, 2'b10, 1'b1, 32'hD4C3_B2A1, 0);

        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("cpl_q_empty", 32'(cpl_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
